// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, redirect flush,
// data-memory wait freeze with sticky timeout, and saturating event counters.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_redirect,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_we,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_we,
  input  logic             mem_mem_read,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_busy, frz, ex_hit, mem_hit, load_use, br_hazard, stall, redirect_flush;

  // A load sitting in MEM always writes back, so only the load flag matters there.
  logic unused_mem_we;
  assign unused_mem_we = mem_reg_we;

  function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic use_src);
    return use_src && (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    mem_busy       = dmem_req & ~dmem_ready;
    frz            = mem_busy & ~rst;
    ex_hit         = src_match(ex_rd, id_rs1, id_use_rs1) | src_match(ex_rd, id_rs2, id_use_rs2);
    mem_hit        = src_match(mem_rd, id_rs1, id_use_rs1) | src_match(mem_rd, id_rs2, id_use_rs2);
    load_use       = ex_mem_read & ex_reg_we & ex_hit;
    br_hazard      = (id_branch | id_jump) & ((ex_reg_we & ex_hit) | (mem_mem_read & mem_hit));
    stall          = (load_use | br_hazard) & ~frz;
    redirect_flush = id_redirect & ~stall & ~frz;
  end

  assign freeze      = frz;
  assign pc_stall    = frz | stall;
  assign if_id_stall = frz | stall;
  assign id_ex_flush = stall;
  assign if_id_flush = redirect_flush;
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        wait_d = '0;
        if (mem_busy) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    // The FSM keeps waiting past the limit; only the flag reports it.
    timeout_d = timeout_q | ((state_q == MEM_WAIT) && !dmem_ready && (wait_d == WAIT_MAX));
    if (stall | frz)    stall_cnt_d = sat_inc(stall_cnt_q);
    if (redirect_flush) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (different counter widths / timeouts) on shared
// stimulus, compared every cycle against a behavioural model, plus directed scenarios.
module tb_hazard_ctrl;

  localparam int CW_A = 16;
  localparam int TO_A = 4;
  localparam int CW_B = 2;
  localparam int TO_B = 6;
  localparam longint MAX_A = (longint'(1) << CW_A) - 1;
  localparam longint MAX_B = (longint'(1) << CW_B) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_use_rs1, id_use_rs2, id_branch, id_jump, id_redirect;
  logic       ex_reg_we, ex_mem_read, mem_reg_we, mem_mem_read, dmem_req, dmem_ready;

  logic            a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_flush, a_freeze, a_mem_timeout;
  logic [CW_A-1:0] a_stall_cnt, a_flush_cnt;
  logic            b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush, b_freeze, b_mem_timeout;
  logic [CW_B-1:0] b_stall_cnt, b_flush_cnt;

  hazard_ctrl #(.CNT_W(CW_A), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_branch(id_branch),
    .id_jump(id_jump), .id_redirect(id_redirect), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
    .mem_mem_read(mem_mem_read), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .if_id_flush(a_if_id_flush),
    .id_ex_flush(a_id_ex_flush), .freeze(a_freeze), .mem_timeout(a_mem_timeout),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl #(.CNT_W(CW_B), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_branch(id_branch),
    .id_jump(id_jump), .id_redirect(id_redirect), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
    .mem_mem_read(mem_mem_read), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .freeze(b_freeze), .mem_timeout(b_mem_timeout),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: length of the current memory-wait episode (0 = idle), sticky flags, counts.
  int     ep_a = 0, ep_b = 0;
  bit     tmo_a = 1'b0, tmo_b = 1'b0;
  longint sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;
  bit     e_frz, e_stall, e_flush;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] rd, input logic [4:0] rs, input logic u);
    return u && (rd != 5'd0) && (rd == rs);
  endfunction

  task automatic predict();
    bit ex_src, mem_src, hazard;
    ex_src  = hit(ex_rd, id_rs1, id_use_rs1) || hit(ex_rd, id_rs2, id_use_rs2);
    mem_src = hit(mem_rd, id_rs1, id_use_rs1) || hit(mem_rd, id_rs2, id_use_rs2);
    hazard  = (ex_mem_read && ex_reg_we && ex_src) ||
              ((id_branch || id_jump) && ((ex_reg_we && ex_src) || (mem_mem_read && mem_src)));
    e_frz   = !rst && dmem_req && !dmem_ready;
    e_stall = hazard && !e_frz;
    e_flush = id_redirect && !hazard && !e_frz;
  endtask

  function automatic int next_ep(input int ep);
    if (ep == 0) return (dmem_req && !dmem_ready) ? 1 : 0;
    return dmem_ready ? 0 : ep + 1;
  endfunction

  task automatic settle();
    #3;
    predict();
    chk("freeze",      a_freeze, e_frz);
    chk("pc_stall",    a_pc_stall, e_frz || e_stall);
    chk("if_id_stall", a_if_id_stall, e_frz || e_stall);
    chk("id_ex_flush", a_id_ex_flush, e_stall);
    chk("if_id_flush", a_if_id_flush, e_flush);
    chk("exclusive",   $onehot0({a_freeze, a_id_ex_flush, a_if_id_flush}), 1);
    chk("comb_b", {b_freeze, b_pc_stall, b_if_id_stall, b_id_ex_flush, b_if_id_flush},
        {e_frz, e_frz || e_stall, e_frz || e_stall, e_stall, e_flush});
    chk("stall_cnt_a", a_stall_cnt, sc_a);
    chk("flush_cnt_a", a_flush_cnt, fc_a);
    chk("timeout_a",   a_mem_timeout, tmo_a);
    chk("stall_cnt_b", b_stall_cnt, sc_b);
    chk("flush_cnt_b", b_flush_cnt, fc_b);
    chk("timeout_b",   b_mem_timeout, tmo_b);
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    if (rst) begin
      ep_a = 0; ep_b = 0; tmo_a = 0; tmo_b = 0;
      sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
    end else begin
      if (e_frz || e_stall) begin
        if (sc_a < MAX_A) sc_a++;
        if (sc_b < MAX_B) sc_b++;
      end
      if (e_flush) begin
        if (fc_a < MAX_A) fc_a++;
        if (fc_b < MAX_B) fc_b++;
      end
      ep_a = next_ep(ep_a);
      ep_b = next_ep(ep_b);
      if (ep_a > TO_A) tmo_a = 1;
      if (ep_b > TO_B) tmo_b = 1;
    end
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_branch = 0; id_jump = 0; id_redirect = 0;
    ex_rd = 0; ex_reg_we = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_we = 0; mem_mem_read = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    rst = 1; idle(); tick();
    dmem_req = 1;
    settle(); chk("freeze_blocked_in_reset", a_freeze, 0); tick();
    rst = 0; idle();
    settle(); chk("rst_stall_cnt", a_stall_cnt, 0); chk("rst_timeout", a_mem_timeout, 0); tick();

    // Load-use on rs1
    ex_mem_read = 1; ex_reg_we = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    settle(); chk("lu_pc_stall", a_pc_stall, 1); chk("lu_id_ex_flush", a_id_ex_flush, 1); tick();
    idle();
    settle(); chk("lu_released", a_pc_stall, 0); chk("lu_stall_cnt", a_stall_cnt, 1); tick();

    // x0 never matches
    ex_mem_read = 1; ex_reg_we = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    settle(); chk("x0_no_stall", a_pc_stall, 0); tick();

    // Branch after load, redirect pending throughout
    idle(); id_branch = 1; id_rs2 = 7; id_use_rs2 = 1; id_redirect = 1;
    ex_rd = 7; ex_reg_we = 1; ex_mem_read = 1;
    settle(); chk("bl_stall1", a_id_ex_flush, 1); chk("bl_defer1", a_if_id_flush, 0); tick();
    ex_rd = 0; ex_reg_we = 0; ex_mem_read = 0; mem_rd = 7; mem_reg_we = 1; mem_mem_read = 1;
    settle(); chk("bl_stall2", a_id_ex_flush, 1); chk("bl_defer2", a_if_id_flush, 0); tick();
    mem_rd = 0; mem_reg_we = 0; mem_mem_read = 0;
    settle(); chk("bl_released", a_pc_stall, 0); chk("bl_redirect", a_if_id_flush, 1); tick();
    idle();
    settle(); chk("bl_stall_cnt", a_stall_cnt, 3); chk("bl_flush_cnt", a_flush_cnt, 1); tick();

    // Jump fed by an ALU op: one stall, then forwarding covers it
    id_jump = 1; id_rs1 = 9; id_use_rs1 = 1; ex_rd = 9; ex_reg_we = 1;
    settle(); chk("alu_stall", a_pc_stall, 1); tick();
    ex_rd = 0; ex_reg_we = 0; mem_rd = 9; mem_reg_we = 1;
    settle(); chk("alu_fwd_no_stall", a_pc_stall, 0); tick();

    // Memory wait of 3 cycles with a masked hazard and redirect
    rst = 1; idle(); tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_req = 1; dmem_ready = 0; ex_mem_read = 1; ex_reg_we = 1; ex_rd = 3;
      id_rs1 = 3; id_use_rs1 = 1; id_redirect = 1;
      settle(); chk("mw_freeze", a_freeze, 1); chk("mw_no_bubble", a_id_ex_flush, 0);
      chk("mw_no_flush", a_if_id_flush, 0); tick();
    end
    idle(); dmem_req = 1; dmem_ready = 1;
    settle(); chk("mw_done", a_freeze, 0); tick();
    idle();
    settle(); chk("mw_stall_cnt", a_stall_cnt, 3); chk("mw_flush_cnt", a_flush_cnt, 0);
    chk("mw_no_timeout", a_mem_timeout, 0); tick();

    // Timeout: ready held low for 6 cycles
    for (int i = 0; i < 6; i++) begin
      dmem_req = 1; dmem_ready = 0;
      settle(); chk("to_progress", a_mem_timeout, (i >= 5) ? 1 : 0); tick();
    end
    dmem_ready = 1;
    settle(); chk("to_sticky_ready", a_mem_timeout, 1); tick();
    idle();
    settle(); chk("to_sticky_run", a_mem_timeout, 1); chk("to_b_not_reached", b_mem_timeout, 0); tick();
    dmem_req = 1; dmem_ready = 0;
    settle(); tick(); settle(); tick();
    rst = 1;
    settle(); chk("rst_mid_wait_freeze", a_freeze, 0); tick();
    rst = 0; idle();
    settle(); chk("to_cleared", a_mem_timeout, 0); tick();

    // Saturation: five stall cycles
    rst = 1; idle(); tick(); rst = 0;
    ex_mem_read = 1; ex_reg_we = 1; ex_rd = 12; id_rs2 = 12; id_use_rs2 = 1;
    repeat (5) begin settle(); tick(); end
    idle();
    settle(); chk("sat_b", b_stall_cnt, 3); chk("sat_a", a_stall_cnt, 5); tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = ($urandom_range(0, 3) != 0);
      id_use_rs2   = ($urandom_range(0, 3) != 0);
      id_branch    = ($urandom_range(0, 2) == 0);
      id_jump      = ($urandom_range(0, 5) == 0);
      id_redirect  = ($urandom_range(0, 1) == 0);
      ex_rd        = 5'($urandom_range(0, 3));
      ex_reg_we    = ($urandom_range(0, 1) == 0);
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      mem_rd       = 5'($urandom_range(0, 3));
      mem_reg_we   = ($urandom_range(0, 1) == 0);
      mem_mem_read = ($urandom_range(0, 2) == 0);
      dmem_req     = ($urandom_range(0, 2) == 0);
      dmem_ready   = ($urandom_range(0, 99) < (((n / 200) % 2 == 1) ? 15 : 70));
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-002 SHALL have parameter TIMEOUT, default 255: the maximum number of MEM_WAIT cycles before an error is flagged.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: the ID-stage source registers.
REQ-006 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 bit each: the ID instruction reads the corresponding source.
REQ-007 SHALL have ports id_branch and id_jump, input, 1 bit each: the ID instruction is a conditional branch or a register jump (JALR), resolved in ID.
REQ-008 SHALL have port id_redirect, input, 1 bit: the branch is taken or the jump is in ID, so the PC is redirected.
REQ-009 SHALL have ports ex_rd (5 bits), ex_reg_we (1 bit) and ex_mem_read (1 bit), inputs: the ID/EX destination, write enable and load flag.
REQ-010 SHALL have ports mem_rd (5 bits), mem_reg_we (1 bit) and mem_mem_read (1 bit), inputs: the same information for the EX/MEM latch.
REQ-011 SHALL have ports dmem_req and dmem_ready, input, 1 bit each: the MEM-stage access request and its completion.
REQ-012 SHALL have ports pc_stall and if_id_stall, output, 1 bit each: hold the PC and the IF/ID latch.
REQ-013 SHALL have ports if_id_flush and id_ex_flush, output, 1 bit each: the IF/ID latch becomes a NOP, and a bubble is inserted into ID/EX.
REQ-014 SHALL have port freeze, output, 1 bit: hold every pipeline latch, including EX/MEM and MEM/WB.
REQ-015 SHALL have port mem_timeout, output, 1 bit: a sticky error flag.
REQ-016 SHALL have ports stall_cnt and flush_cnt, output, CNT_W bits each: saturating event counters.

Function
REQ-017 SHALL implement a state machine with the states RUN and MEM_WAIT.
REQ-018 SHALL, in RUN, move to MEM_WAIT at the next edge when dmem_req=1 and dmem_ready=0.
REQ-019 SHALL, in MEM_WAIT, return to RUN at the edge on which dmem_ready=1.
REQ-020 SHALL drive freeze=1 combinationally whenever dmem_req=1 and dmem_ready=0, in either state; the first waiting cycle is therefore frozen.
REQ-021 SHALL, while freeze=1, force if_id_flush=0 and id_ex_flush=0 (no bubble and no flush while frozen) and drive pc_stall=1 and if_id_stall=1.
REQ-022 SHALL define a match on register x as: x != 0, and the corresponding use bit is 1.
REQ-023 SHALL assert load_use when ex_mem_read=1, ex_reg_we=1 and ex_rd matches id_rs1 or id_rs2.
REQ-024 SHALL assert br_hazard when (id_branch or id_jump) and either:
- ex_reg_we=1 with ex_rd matching a used source, or
- mem_mem_read=1 with mem_rd matching a used source.
REQ-025 SHALL assert stall = load_use OR br_hazard, when not frozen.
REQ-026 SHALL, on stall, drive pc_stall=1, if_id_stall=1 and id_ex_flush=1 in the same cycle (combinational, zero latency).
REQ-027 SHALL make a branch whose source is produced by a load currently in EX stall 2 cycles: one cycle for the EX match, then one for the MEM-load match as the pipeline advances.
REQ-028 SHALL make a branch whose source is produced by an ALU op in EX stall exactly 1 cycle; forwarding from EX/MEM then covers it.
REQ-029 SHALL drive if_id_flush=1 only when id_redirect=1, stall=0 and freeze=0.
REQ-030 SHALL ignore id_redirect while the branch is stalled; it is honoured in the first non-stalled cycle.
REQ-031 SHALL apply the priority freeze > stall > redirect flush; at most one of the groups {freeze}, {stall outputs} and {if_id_flush} is active per cycle.
REQ-032 SHALL treat ex_rd=0 and mem_rd=0 as never matching.
REQ-033 SHALL maintain a wait counter that counts up each cycle in MEM_WAIT and clears on entering RUN.
REQ-034 SHALL set mem_timeout=1 when the wait counter reaches TIMEOUT; the flag stays 1 until rst; the FSM keeps waiting.
REQ-035 SHALL increment stall_cnt on every cycle with stall=1 or freeze=1, saturating at all-ones (no wrap).
REQ-036 SHALL increment flush_cnt on every cycle with if_id_flush=1, saturating at all-ones.

Reset
REQ-037 SHALL, on rst=1 at a clock edge, set the state to RUN, the wait counter to 0, mem_timeout=0, stall_cnt=0 and flush_cnt=0.
REQ-038 SHALL take reset priority over all other events, including reset asserted mid MEM_WAIT.
REQ-039 SHALL keep the combinational outputs input-driven during reset, but block freeze; only RUN-state rules apply.

Verification
REQ-040 SHALL be verified for load-use: ex_mem_read=1, ex_reg_we=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 for one cycle, stall_cnt=1.
REQ-041 SHALL be verified for a branch after load: id_branch=1 with rs2=7 matching ex_rd=7 (load), then next cycle mem_rd=7 with mem_mem_read=1 -> 2 stall cycles, then if_id_flush=1 when id_redirect=1.
REQ-042 SHALL be verified for memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> freeze=1 for 3 cycles, state back to RUN, stall_cnt=3, no flush outputs.
REQ-043 SHALL be verified for timeout: TIMEOUT=4, dmem_ready held 0 for 6 cycles -> mem_timeout=1 from the cycle the counter reaches 4, still 1 after dmem_ready=1, cleared only by rst.
REQ-044 SHALL be verified for x0: ex_rd=0, ex_mem_read=1, id_rs1=0 -> no stall.
REQ-045 SHALL be verified for simultaneous events: a load-use stall concurrent with id_redirect=1 -> stall only; if_id_flush is deferred.
REQ-046 SHALL be verified for saturation: CNT_W=2 with 5 stall cycles -> stall_cnt=3.
